// File: rtl/gf163_digit_serializer.sv
// gf163_digit_serializer: 163-bit operand -> six registered 32-bit digits over valid/ready; DIGIT_LSB_FIRST_EN selects LSB-first order
module gf163_digit_serializer #(
  parameter int M    = 163,
  parameter int D    = 32,
  parameter int NDIG = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [M-1:0] op_in,
  input  logic         op_valid,
  output logic         op_ready,
  output logic [D-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [2:0]   dout_idx,
  output logic         dout_last,
  output logic         busy
);
  localparam int W = NDIG * D;
  typedef enum logic {IDLE, SEND} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d, ext, shifted;
  logic [D-1:0]   dout_q, dout_d, first_dig, next_dig;
  logic [2:0]     idx_q, idx_d;
  logic           last_q, last_d, accept, xfer;
  assign ext = {{(W-M){1'b0}}, op_in};
`ifdef DIGIT_LSB_FIRST_EN
  assign first_dig = ext[D-1:0];
  assign next_dig  = shreg_q[2*D-1:D];
  assign shifted   = shreg_q >> D;
`else
  assign first_dig = ext[W-1:W-D];
  assign next_dig  = shreg_q[W-D-1:W-2*D];
  assign shifted   = shreg_q << D;
`endif
  assign busy       = state_q == SEND;
  assign dout_valid = busy;
  assign op_ready   = !busy || (last_q && dout_ready);
  assign accept     = op_valid && op_ready;
  assign xfer       = busy && dout_ready;
  assign dout       = dout_q;
  assign dout_idx   = idx_q;
  assign dout_last  = last_q;
  // Load a new operand on accept (also on the final digit's transfer), else advance one digit per transfer
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (accept) begin
      state_d = SEND;
      shreg_d = ext;
      dout_d  = first_dig;
      idx_d   = 3'd0;
      last_d  = 1'b0;
    end else if (xfer) begin
      state_d = last_q ? IDLE : SEND;
      shreg_d = last_q ? shreg_q : shifted;
      dout_d  = last_q ? dout_q : next_dig;
      idx_d   = last_q ? idx_q : idx_q + 3'd1;
      last_d  = last_q ? last_q : (idx_q == 3'(NDIG - 2));
    end
  end
  // State and digit registers, cleared asynchronously so a partial operand is dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dout_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_gf163_digit_serializer.sv
// tb_gf163_digit_serializer: random and directed stimulus against a digit-queue reference model
module tb_gf163_digit_serializer;
  logic         clk = 1'b0, rstn = 1'b0;
  logic [162:0] op_in = '0;
  logic         op_valid = 1'b0, dout_ready = 1'b0;
  logic         op_ready, dout_valid, dout_last, busy;
  logic [31:0]  dout;
  logic [2:0]   dout_idx;
  int           checks = 0, failures = 0;
  logic [31:0]  dq[$];
  int           iq[$];
  logic [162:0] a, b;
  gf163_digit_serializer dut (
    .clk(clk), .rstn(rstn), .op_in(op_in), .op_valid(op_valid), .op_ready(op_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_idx(dout_idx),
    .dout_last(dout_last), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] digit(input logic [162:0] op, input int i);
    logic [191:0] e;
    e = {29'b0, op};
`ifdef DIGIT_LSB_FIRST_EN
    return 32'(e >> (32 * i));
`else
    return 32'(e >> (32 * (5 - i)));
`endif
  endfunction
  function automatic logic [162:0] rnd_op();
    return 163'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction
  task automatic cyc(input logic v, input logic [162:0] d, input logic r);
    logic pend, rdy;
    pend = dq.size() > 0;
    check("dout_valid", dout_valid, pend);
    check("busy", busy, pend);
    if (pend) begin
      check("dout", dout, dq[0]);
      check("dout_idx", dout_idx, iq[0]);
      check("dout_last", dout_last, iq[0] == 5);
    end
    op_valid = v; op_in = d; dout_ready = r;
    #1;
    rdy = !pend || (dq.size() == 1 && r);
    check("op_ready", op_ready, rdy);
    if (pend && r) begin
      void'(dq.pop_front());
      void'(iq.pop_front());
    end
    if (v && rdy)
      for (int i = 0; i < 6; i++) begin
        dq.push_back(digit(d, i));
        iq.push_back(i);
      end
    @(negedge clk);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_idx"}, dout_idx, 0);
    check({tag, "_last"}, dout_last, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    a = (163'b1 << 162) | 163'b1;
    cyc(1, a, 1);
    repeat (7) cyc(0, '0, 1);
    check("hold_dout", dout, digit(a, 5));
    a = '1;
    cyc(1, a, 1);
    repeat (7) cyc(0, '0, 1);
    cyc(1, rnd_op(), 1);
    repeat (2) cyc(0, rnd_op(), 1);
    repeat (3) cyc(0, rnd_op(), 0);
    repeat (5) cyc(0, '0, 1);
    a = rnd_op();
    b = 163'h1;
    cyc(1, a, 1);
    repeat (6) cyc(1, b, 1);
    repeat (7) cyc(0, '0, 1);
    cyc(1, rnd_op(), 1);
    repeat (3) cyc(0, '0, 1);
    #2 rstn = 1'b0;
    #1 check_zero("async_rst");
    dq.delete();
    iq.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) cyc(0, rnd_op(), 1);
    for (int n = 0; n < 500; n++)
      cyc($urandom_range(0, 2) != 0, rnd_op(), $urandom_range(0, 3) != 0);
    repeat (30) cyc(0, '0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
